// File: rtl/lut6_cfg_reg.sv
// Runtime-reconfigurable 6-input LUT with a registered output.
// Truth table is loaded bit-serially (CE/CDI) or as a 64-bit word serialised by a loader FSM.
module lut6_cfg_reg #(
  parameter logic [63:0] INIT = 64'h0000000000000000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic        CDI,
  output logic        CDO,
  input  logic        I0,
  input  logic        I1,
  input  logic        I2,
  input  logic        I3,
  input  logic        I4,
  input  logic        I5,
  output logic        O,
  output logic        Q,
  input  logic        LOAD_VLD,
  input  logic [63:0] LOAD_DATA,
  output logic        LOAD_RDY,
  output logic        BUSY,
  output logic        LOAD_DONE
);

  // state | meaning
  // IDLE  | table stable; serial CE shifts and parallel handshakes accepted
  // SHIFT | loader pushing stage MSB first into cfg, 64 cycles
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] cfg_q, cfg_d;
  logic [63:0] stage_q, stage_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        q_q;
  logic [5:0]  idx;

  assign idx       = {I5, I4, I3, I2, I1, I0};
  assign O         = cfg_q[idx];
  assign CDO       = cfg_q[63];
  assign Q         = q_q;
  assign LOAD_DONE = done_q;
  assign BUSY      = (state_q == SHIFT);
  // Ready is masked while reset is held so no handshake is seen during CLR.
  assign LOAD_RDY  = (state_q == IDLE) && !CLR;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cfg_q   <= INIT;
      stage_q <= 64'h0;
      cnt_q   <= 6'd0;
      done_q  <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      q_q     <= O;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CE) cfg_d = {cfg_q[62:0], CDI};
        if (LOAD_VLD) begin
          stage_d = LOAD_DATA;
          cnt_d   = 6'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cfg_d   = {cfg_q[62:0], stage_q[63]};
        stage_d = {stage_q[62:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lut6_cfg_reg.sv
// Directed bench for lut6_cfg_reg: vector table for lookups plus sequences for
// parallel/serial loads, coincident events, back-to-back loads and reset mid-load.
`timescale 1ns/1ps
module tb_lut6_cfg_reg;

  localparam logic [63:0] INIT_V = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PAR_V  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] SER_V  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] X_V    = 64'h5A5A_0F0F_C3C3_9696;
  localparam logic [63:0] Y_V    = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] A_V    = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] Z_V    = 64'hDEAD_BEEF_0123_4567;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        CE = 1'b0;
  logic        CDI = 1'b0;
  logic        CDO;
  logic [5:0]  idx = 6'd0;
  logic        O, Q;
  logic        LOAD_VLD = 1'b0;
  logic [63:0] LOAD_DATA = 64'h0;
  logic        LOAD_RDY, BUSY, LOAD_DONE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  lut6_cfg_reg #(.INIT(INIT_V)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .CDI(CDI), .CDO(CDO),
    .I0(idx[0]), .I1(idx[1]), .I2(idx[2]), .I3(idx[3]), .I4(idx[4]), .I5(idx[5]),
    .O(O), .Q(Q),
    .LOAD_VLD(LOAD_VLD), .LOAD_DATA(LOAD_DATA),
    .LOAD_RDY(LOAD_RDY), .BUSY(BUSY), .LOAD_DONE(LOAD_DONE)
  );

  typedef struct {
    int         phase;
    logic [5:0] sel;
    logic       exp_o;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Sweep all indices through O; table must be stable (idle or reset) meanwhile.
  task automatic read_table(output logic [63:0] w);
    for (int n = 0; n < 64; n++) begin
      idx = 6'(n);
      #1;
      w[n] = O;
    end
    idx = 6'd0;
    @(negedge CLK);
  endtask

  task automatic run_vectors(input int ph);
    for (int v = 0; v < 17; v++) begin
      if (vecs[v].phase == ph) begin
        idx = vecs[v].sel;
        #1;
        check($sformatf("vec_p%0d_idx%02h", ph, vecs[v].sel), {63'h0, O}, {63'h0, vecs[v].exp_o});
      end
    end
    idx = 6'd0;
    @(negedge CLK);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] cdo_w;
    int          busy_low;
    int          done_cnt;
    int          cyc;

    vecs[0]  = '{0, 6'h00, 1'b1};
    vecs[1]  = '{0, 6'h3F, 1'b1};
    vecs[2]  = '{0, 6'h01, 1'b0};
    vecs[3]  = '{0, 6'h20, 1'b0};
    vecs[4]  = '{0, 6'h3E, 1'b0};
    vecs[5]  = '{1, 6'h00, 1'b0};
    vecs[6]  = '{1, 6'h10, 1'b1};
    vecs[7]  = '{1, 6'h1F, 1'b1};
    vecs[8]  = '{1, 6'h20, 1'b0};
    vecs[9]  = '{1, 6'h30, 1'b1};
    vecs[10] = '{1, 6'h3F, 1'b1};
    vecs[11] = '{1, 6'h2F, 1'b0};
    vecs[12] = '{2, 6'h00, 1'b1};
    vecs[13] = '{2, 6'h04, 1'b0};
    vecs[14] = '{2, 6'h3F, 1'b0};
    vecs[15] = '{2, 6'h38, 1'b1};
    vecs[16] = '{2, 6'h05, 1'b1};

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_o", {63'h0, O}, 64'h1);
    check("rst_q", {63'h0, Q}, 64'h0);
    check("rst_cdo", {63'h0, CDO}, 64'h1);
    check("rst_rdy", {63'h0, LOAD_RDY}, 64'h0);
    check("rst_busy", {63'h0, BUSY}, 64'h0);
    check("rst_done", {63'h0, LOAD_DONE}, 64'h0);
    CLR = 1'b0;
    #1;
    check("q_before_edge", {63'h0, Q}, 64'h0);
    @(posedge CLK);
    #1;
    check("q_after_edge", {63'h0, Q}, 64'h1);
    @(negedge CLK);
    check("idle_rdy", {63'h0, LOAD_RDY}, 64'h1);
    check("idle_busy", {63'h0, BUSY}, 64'h0);
    run_vectors(0);

    // Parallel load, observing the old table stream out on CDO
    LOAD_VLD = 1'b1;
    LOAD_DATA = PAR_V;
    tick();
    LOAD_VLD = 1'b0;
    busy_low = 0;
    done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cdo_w[63-i] = CDO;
      if (!BUSY) busy_low++;
      if (LOAD_DONE) done_cnt++;
      tick();
    end
    check("par_busy_low_cycles", 64'(busy_low), 64'd0);
    check("par_early_done", 64'(done_cnt), 64'd0);
    check("par_cdo_stream", cdo_w, INIT_V);
    check("par_done_pulse", {63'h0, LOAD_DONE}, 64'h1);
    check("par_busy_end", {63'h0, BUSY}, 64'h0);
    check("par_rdy_end", {63'h0, LOAD_RDY}, 64'h1);
    tick();
    check("par_done_clear", {63'h0, LOAD_DONE}, 64'h0);
    read_table(w);
    check("par_table", w, PAR_V);
    run_vectors(1);

    // Serial load MSB first, then CE=0 must leave it alone
    for (int i = 0; i < 64; i++) begin
      CE = 1'b1;
      CDI = SER_V[63-i];
      tick();
    end
    CE = 1'b0;
    read_table(w);
    check("ser_table", w, SER_V);
    for (int i = 0; i < 5; i++) begin
      CDI = ~CDI;
      tick();
    end
    read_table(w);
    check("ser_hold_ce0", w, SER_V);
    run_vectors(2);

    // Coincident CE shift + handshake, LOAD_VLD held through SHIFT, back-to-back load
    idx = 6'h05;
    CE = 1'b1;
    CDI = 1'b1;
    LOAD_VLD = 1'b1;
    LOAD_DATA = X_V;
    tick();
    CE = 1'b0;
    LOAD_DATA = Y_V;
    check("coinc_serial_bit", {63'h0, O}, 64'h0);
    check("coinc_busy", {63'h0, BUSY}, 64'h1);
    done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (LOAD_DONE) done_cnt++;
    end
    check("coinc_done_count", 64'(done_cnt), 64'd1);
    check("coinc_done_at_64", {63'h0, LOAD_DONE}, 64'h1);
    check("coinc_rdy_at_64", {63'h0, LOAD_RDY}, 64'h1);
    tick();
    LOAD_VLD = 1'b0;
    idx = 6'd0;
    check("b2b_accepted", {63'h0, BUSY}, 64'h1);
    check("b2b_done_low", {63'h0, LOAD_DONE}, 64'h0);
    busy_low = 0;
    for (int i = 0; i < 64; i++) begin
      cdo_w[63-i] = CDO;
      if (!BUSY) busy_low++;
      CE = 1'($urandom_range(0, 1));
      CDI = 1'($urandom_range(0, 1));
      LOAD_VLD = 1'b1;
      LOAD_DATA = A_V;
      tick();
    end
    CE = 1'b0;
    LOAD_VLD = 1'b0;
    check("b2b_busy_low_cycles", 64'(busy_low), 64'd0);
    check("b2b_cdo_is_x", cdo_w, X_V);
    check("b2b_done", {63'h0, LOAD_DONE}, 64'h1);
    tick();
    read_table(w);
    check("b2b_table", w, Y_V);

    // Reset mid-shift
    LOAD_VLD = 1'b1;
    LOAD_DATA = A_V;
    tick();
    LOAD_VLD = 1'b0;
    repeat (30) tick();
    #2;
    CLR = 1'b1;
    #1;
    check("midrst_busy", {63'h0, BUSY}, 64'h0);
    check("midrst_rdy", {63'h0, LOAD_RDY}, 64'h0);
    check("midrst_cdo", {63'h0, CDO}, 64'h1);
    read_table(w);
    check("midrst_table", w, INIT_V);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (LOAD_DONE) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    CLR = 1'b0;
    LOAD_VLD = 1'b1;
    LOAD_DATA = Z_V;
    tick();
    LOAD_VLD = 1'b0;
    check("post_rst_accept", {63'h0, BUSY}, 64'h1);
    cyc = 0;
    while (!LOAD_DONE && cyc < 100) begin
      tick();
      cyc++;
    end
    check("post_rst_latency", 64'(cyc), 64'd64);
    tick();
    read_table(w);
    check("post_rst_table", w, Z_V);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
